// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and elaboration helpers for pipelined_addsub.
// The sat_value helper is used only when PIPELINED_ADDSUB_SATURATE_EN is defined.
package pipelined_addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Upper bound on WIDTH for the saturation helpers; callers slice down.
  localparam int unsigned MAX_W = 1024;

  function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Width of chunk k; only the last chunk can be narrower than CHUNK.
  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned chunk,
                                          input int unsigned k);
    return (k == stages(width, chunk) - 1) ? width - k * chunk : chunk;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
    return MAX_W'(1) << (width - 1);
  endfunction

  // Clamp value chosen by the sign of operand a.
  function automatic logic [MAX_W-1:0] sat_value(input logic neg, input int unsigned width);
    return neg ? sat_min(width) : sat_max(width);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: resolves a CW-bit slice of the carry chain and holds its result.
// With PIPELINED_ADDSUB_SATURATE_EN defined, the last stage clamps on signed overflow.
module addsub_stage
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4,
  parameter int unsigned LSB   = 0,
  parameter bit          LAST  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             advance,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             sub,
  output logic             c,
  output logic             v
);

  localparam int unsigned MSB = LSB + CW - 1;

  logic [CW:0]      sum_c;
  logic             carry_msb_c;
  logic             v_c;
  logic [WIDTH-1:0] s_c;

  // Chunk adder; b is already inverted upstream for subtraction.
  always_comb begin
    sum_c       = {1'b0, in_a[LSB +: CW]} + {1'b0, in_b[LSB +: CW]} + {{CW{1'b0}}, in_carry};
    carry_msb_c = in_a[MSB] ^ in_b[MSB] ^ sum_c[CW-1];
    v_c         = carry_msb_c ^ sum_c[CW];
    s_c         = in_s;
    s_c[LSB +: CW] = sum_c[CW-1:0];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (LAST && v_c) s_c = WIDTH'(sat_value(in_a[WIDTH-1], WIDTH));
`endif
  end

  // Stage register: loads only on an advancing valid op, otherwise holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      carry <= 1'b0;
      sub   <= 1'b0;
      c     <= 1'b0;
      v     <= 1'b0;
    end else if (advance) begin
      valid <= in_valid;
      if (in_valid) begin
        a     <= in_a;
        b     <= in_b;
        s     <= s_c;
        carry <= sum_c[CW];
        sub   <= in_sub;
        c     <= sum_c[CW] ^ in_sub;
        v     <= v_c;
      end
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract with the carry chain split into CHUNK-bit pipeline stages.
// Optional output clamping on overflow: define PIPELINED_ADDSUB_SATURATE_EN.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_sub,
  input  logic             io_in_cin,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  output logic [WIDTH-1:0] io_out_s,
  output logic             io_out_c,
  output logic             io_out_v,
  output logic             io_out_valid,
  input  logic             io_out_ready
);

  localparam int unsigned STAGES = stages(WIDTH, CHUNK);

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic             st_valid [STAGES+1];
  logic [WIDTH-1:0] st_a     [STAGES+1];
  logic [WIDTH-1:0] st_b     [STAGES+1];
  logic [WIDTH-1:0] st_s     [STAGES+1];
  logic             st_carry [STAGES+1];
  logic             st_sub   [STAGES+1];
  logic             st_c     [STAGES];
  logic             st_v     [STAGES];
  logic [STAGES-1:0] adv_c;

  assign st_valid[0] = io_in_valid;
  assign st_a[0]     = io_in_a;
  assign st_b[0]     = (io_in_sub == SUB) ? ~io_in_b : io_in_b;
  assign st_s[0]     = '0;
  assign st_carry[0] = (io_in_sub == SUB) ? ~io_in_cin : io_in_cin;
  assign st_sub[0]   = io_in_sub;

  // Backpressure chain: a stage moves if it is empty or the one after it moves.
  always_comb begin
    logic chain;
    chain = io_out_ready;
    adv_c = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      chain    = !st_valid[k+1] || chain;
      adv_c[k] = chain;
    end
  end

  assign io_in_ready = adv_c[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned CW = chunk_w(WIDTH, CHUNK, k);
    addsub_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .LSB   (k * CHUNK),
      .LAST  (k == STAGES - 1)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .in_valid (st_valid[k]),
      .advance  (adv_c[k]),
      .in_a     (st_a[k]),
      .in_b     (st_b[k]),
      .in_s     (st_s[k]),
      .in_carry (st_carry[k]),
      .in_sub   (st_sub[k]),
      .valid    (st_valid[k+1]),
      .a        (st_a[k+1]),
      .b        (st_b[k+1]),
      .s        (st_s[k+1]),
      .carry    (st_carry[k+1]),
      .sub      (st_sub[k+1]),
      .c        (st_c[k]),
      .v        (st_v[k])
    );
  end

  assign io_out_valid = st_valid[STAGES];
  assign io_out_s     = st_s[STAGES];
  assign io_out_c     = st_c[STAGES-1];
  assign io_out_v     = st_v[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 8-bit/4-bit instance plus a 12-bit/5-bit instance.
// Expected values adapt when PIPELINED_ADDSUB_SATURATE_EN is defined.
module tb_pipelined_addsub;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [7:0]  in_a, in_b, out_s;
  logic        in_sub, in_cin, in_valid, in_ready;
  logic        out_c, out_v, out_valid, out_ready;

  logic [11:0] w_a, w_b, w_s;
  logic        w_sub, w_cin, w_in_valid, w_in_ready;
  logic        w_c, w_v, w_out_valid, w_out_ready;

  int checks   = 0;
  int failures = 0;

`ifdef PIPELINED_ADDSUB_SATURATE_EN
  localparam logic [7:0]  E_7F_P1  = 8'h7F;
  localparam logic [7:0]  E_80_M1  = 8'h80;
  localparam logic [7:0]  E_80_P80 = 8'h80;
  localparam logic [11:0] E_W_OVF  = 12'h7FF;
`else
  localparam logic [7:0]  E_7F_P1  = 8'h80;
  localparam logic [7:0]  E_80_M1  = 8'h7F;
  localparam logic [7:0]  E_80_P80 = 8'h00;
  localparam logic [11:0] E_W_OVF  = 12'h800;
`endif

  pipelined_addsub #(.WIDTH(8), .CHUNK(4)) u_dut (
    .clock(clock), .reset(reset),
    .io_in_a(in_a), .io_in_b(in_b), .io_in_sub(in_sub), .io_in_cin(in_cin),
    .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_out_s(out_s), .io_out_c(out_c), .io_out_v(out_v),
    .io_out_valid(out_valid), .io_out_ready(out_ready)
  );

  pipelined_addsub #(.WIDTH(12), .CHUNK(5)) u_wide (
    .clock(clock), .reset(reset),
    .io_in_a(w_a), .io_in_b(w_b), .io_in_sub(w_sub), .io_in_cin(w_cin),
    .io_in_valid(w_in_valid), .io_in_ready(w_in_ready),
    .io_out_s(w_s), .io_out_c(w_c), .io_out_v(w_v),
    .io_out_valid(w_out_valid), .io_out_ready(w_out_ready)
  );

  // Reference arithmetic for random streaming: returns {s, c, v}.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic sub, input logic cin);
    logic [8:0] r;
    logic [7:0] s;
    logic       v;
    if (!sub) r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    else      r = {1'b0, a} - {1'b0, b} - {8'd0, cin};
    s = r[7:0];
    v = sub ? (a[7] != b[7] && s[7] != a[7]) : (a[7] == b[7] && s[7] != a[7]);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (v) s = a[7] ? 8'h80 : 8'h7F;
`endif
    return {s, r[8], v};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if ({out_s, out_c, out_v} !== 10'd0) begin failures++; $display("FAIL reset_data got=%h exp=000", {out_s, out_c, out_v}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (w_out_valid !== 1'b0 || w_s !== 12'h000) begin failures++; $display("FAIL reset_wide got=%b/%h exp=0/000", w_out_valid, w_s); end
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_arith();
    logic [7:0] va [10];
    logic [7:0] vb [10];
    logic       vs [10];
    logic       vc [10];
    logic [9:0] ve [10];
    int lat;
    va = '{8'h05, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h12, 8'h10, 8'h80, 8'h0F, 8'h00};
    vb = '{8'h07, 8'h01, 8'h01, 8'h01, 8'h01, 8'h34, 8'h0F, 8'h80, 8'h01, 8'h00};
    vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ve = '{{8'hFE, 2'b10}, {8'h00, 2'b10}, {E_7F_P1, 2'b01}, {E_80_M1, 2'b01}, {8'hFF, 2'b10},
           {8'h47, 2'b00}, {8'h00, 2'b00}, {E_80_P80, 2'b11}, {8'h10, 2'b00}, {8'hFF, 2'b10}};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = va[i]; in_b = vb[i]; in_sub = vs[i]; in_cin = vc[i]; in_valid = 1'b1;
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arith_ready[%0d] got=%b exp=1", i, in_ready); end
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin @(posedge clock); #1; lat++; end
      checks++; if (lat != 2) begin failures++; $display("FAIL arith_latency[%0d] got=%0d exp=2", i, lat); end
      checks++; if ({out_s, out_c, out_v} !== ve[i]) begin failures++; $display("FAIL arith_result[%0d] got=%h exp=%h", i, {out_s, out_c, out_v}, ve[i]); end
      @(posedge clock); #1;
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", out_valid); end
    checks++; if (out_s !== 8'hFF) begin failures++; $display("FAIL empty_hold got=%h exp=ff", out_s); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba [5];
    logic [7:0] bb [5];
    logic       bs [5];
    logic       bc [5];
    logic [9:0] be [5];
    logic       rdy_exp [8];
    int si, ri;
    ba = '{8'h01, 8'h10, 8'h50, 8'h10, 8'hF0};
    bb = '{8'h02, 8'h20, 8'h10, 8'h50, 8'h20};
    bs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    be = '{{8'h03, 2'b00}, {8'h31, 2'b00}, {8'h40, 2'b00}, {8'hC0, 2'b10}, {8'h10, 2'b10}};
    rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    si = 0; ri = 0;
    for (int cyc = 0; cyc < 40 && ri < 5; cyc++) begin
      out_ready = (cyc >= 4);
      if (si < 5) begin
        in_a = ba[si]; in_b = bb[si]; in_sub = bs[si]; in_cin = bc[si]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clock);
      if (cyc < 8) begin
        checks++; if (in_ready !== rdy_exp[cyc]) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=%b", cyc, in_ready, rdy_exp[cyc]); end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if ({out_s, out_c, out_v} !== be[ri]) begin
          failures++;
          $display("FAIL bp_%s[%0d] got=%h exp=%h", out_ready ? "result" : "hold", ri, {out_s, out_c, out_v}, be[ri]);
        end
        if (out_ready) ri++;
      end
      if (in_valid && in_ready) si++;
      @(posedge clock); #1;
    end
    checks++; if (si != 5 || ri != 5) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=5/5", si, ri); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra[%0d] got=%b exp=0", i, out_valid); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_stream();
    logic [7:0] sa [100];
    logic [7:0] sb [100];
    logic       ss [100];
    logic       sc [100];
    int si, ri, first, last;
    for (int i = 0; i < 100; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom); ss[i] = 1'($urandom); sc[i] = 1'($urandom);
    end
    si = 0; ri = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && ri < 100; cyc++) begin
      if (si < 100) begin
        in_a = sa[si]; in_b = sb[si]; in_sub = ss[si]; in_cin = sc[si]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clock);
      if (out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if ({out_s, out_c, out_v} !== model8(sa[ri], sb[ri], ss[ri], sc[ri])) begin
          failures++;
          $display("FAIL stream[%0d] got=%h exp=%h", ri, {out_s, out_c, out_v}, model8(sa[ri], sb[ri], ss[ri], sc[ri]));
        end
        ri++;
      end
      if (in_valid && in_ready) si++;
      @(posedge clock); #1;
    end
    checks++; if (ri != 100) begin failures++; $display("FAIL stream_count got=%0d exp=100", ri); end
    checks++; if (first != 2 || last != 101) begin failures++; $display("FAIL stream_rate got=%0d..%0d exp=2..101", first, last); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_a = 8'h11; in_b = 8'h22; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_a = 8'h33; in_b = 8'h01;
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (out_s !== 8'h00) begin failures++; $display("FAIL arst_data got=%h exp=00", out_s); end
    @(posedge clock);
    @(negedge clock) begin reset = 1'b1; out_ready = 1'b1; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_after[%0d] got=%b/%b exp=0/1", i, out_valid, in_ready); end
    end
    @(posedge clock); #1;
    in_a = 8'h01; in_b = 8'h01; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b1 || out_s !== 8'h02) begin failures++; $display("FAIL arst_new got=%b/%h exp=1/02", out_valid, out_s); end
    @(posedge clock); #1;
  endtask

  task automatic test_wide();
    logic [11:0] xa [3];
    logic [11:0] xb [3];
    logic        xs [3];
    logic        xc [3];
    logic [13:0] xe [3];
    int lat;
    xa = '{12'h000, 12'h3FF, 12'h7FF};
    xb = '{12'h001, 12'h001, 12'h001};
    xs = '{1'b1, 1'b0, 1'b0};
    xc = '{1'b1, 1'b0, 1'b0};
    xe = '{{12'hFFE, 2'b10}, {12'h400, 2'b00}, {E_W_OVF, 2'b01}};
    w_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_a = xa[i]; w_b = xb[i]; w_sub = xs[i]; w_cin = xc[i]; w_in_valid = 1'b1;
      @(posedge clock); #1;
      w_in_valid = 1'b0;
      lat = 1;
      while (w_out_valid !== 1'b1 && lat < 10) begin @(posedge clock); #1; lat++; end
      checks++; if (lat != 3) begin failures++; $display("FAIL wide_latency[%0d] got=%0d exp=3", i, lat); end
      checks++; if ({w_s, w_c, w_v} !== xe[i]) begin failures++; $display("FAIL wide_result[%0d] got=%h exp=%h", i, {w_s, w_c, w_v}, xe[i]); end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    w_a = '0; w_b = '0; w_sub = 1'b0; w_cin = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    test_reset();
    test_arith();
    test_backpressure();
    test_stream();
    test_async_reset();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
